// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target: FSM state encoding,
// bus ACK/NACK levels, the R/W bit position and the majority-vote helper.
package i2c_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE      = 4'd0;
   localparam state_t ST_ADDR      = 4'd1;
   localparam state_t ST_ADDR_ACK  = 4'd2;
   localparam state_t ST_PTR       = 4'd3;
   localparam state_t ST_WR_DATA   = 4'd4;
   localparam state_t ST_WR_ACK    = 4'd5;
   localparam state_t ST_RD_DATA   = 4'd6;
   localparam state_t ST_RD_ACK    = 4'd7;
   localparam state_t ST_WAIT_STOP = 4'd8;

   localparam logic ACK_LVL  = 1'b0;
   localparam logic NACK_LVL = 1'b1;

   localparam int RW_BIT = 0;

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Pin-level and register-bus signals of the I2C target, grouped for port lists.
// slave = the target block itself, master = whatever drives the bus and serves registers.
interface i2c_target_if;

   logic       I_SCL;
   logic       I_SDA;
   logic       O_SDA_OE;
   logic       O_WR_EN;
   logic       O_RD_EN;
   logic [7:0] O_ADDR;
   logic [7:0] O_WDATA;
   logic [7:0] I_RDATA;
   logic       O_BUSY;

   modport slave (
      input  I_SCL, I_SDA, I_RDATA,
      output O_SDA_OE, O_WR_EN, O_RD_EN, O_ADDR, O_WDATA, O_BUSY
   );

   modport master (
      output I_SCL, I_SDA, I_RDATA,
      input  O_SDA_OE, O_WR_EN, O_RD_EN, O_ADDR, O_WDATA, O_BUSY
   );

endinterface

// File: rtl/i2c_line_filter.sv
// One bus line: 2-FF synchronizer, optional 3-sample majority filter
// (I2C_TARGET_GLITCH_FILTER_EN) and rise/fall detection on the cleaned level.
module i2c_line_filter
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [1:0] sync_q;
   logic       level;
   logic       prev_q;

   // NOTE: flops reset to 1 (idle bus) so leaving reset never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], line_i};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [2:0] win_q;
   logic       filt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q  <= 3'b111;
         filt_q <= 1'b1;
      end else begin
         win_q  <= {win_q[1:0], sync_q[1]};
         filt_q <= majority3(win_q);
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q[1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= level;
      end
   end

   assign level_o = level;
   assign rise_o  = level & ~prev_q;
   assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer: pointer byte, auto-incrementing
// writes and prefetched reads. Optional glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h42
) (
   input  logic          I_CLK,
   input  logic          I_RESETN,
   i2c_target_if.slave   bus
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter u_scl (
      .clk    (I_CLK),
      .rst_n  (I_RESETN),
      .line_i (bus.I_SCL),
      .level_o(scl_lvl),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   i2c_line_filter u_sda (
      .clk    (I_CLK),
      .rst_n  (I_RESETN),
      .line_i (bus.I_SDA),
      .level_o(sda_lvl),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   logic start_det, stop_det;
   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   state_t     state_q,     state_d;
   logic [3:0] cnt_q,       cnt_d;
   logic [7:0] shift_q,     shift_d;
   logic [7:0] ptr_q,       ptr_d;
   logic [7:0] wdata_q,     wdata_d;
   logic       rw_q,        rw_d;
   logic       ptr_phase_q, ptr_phase_d;
   logic       mack_q,      mack_d;
   logic       sda_oe_q,    sda_oe_d;
   logic       wr_en_q,     wr_en_d;
   logic       rd_en_q,     rd_en_d;
   logic       rd_pend_q;
   logic       busy_q,      busy_d;

   logic [7:0] rx_byte;
   logic       rx_done;
   assign rx_byte = {shift_q[6:0], sda_lvl};
   assign rx_done = scl_rise && (cnt_q == 4'd7);

   // NOTE: every _d signal is defaulted first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      wdata_d     = wdata_q;
      rw_d        = rw_q;
      ptr_phase_d = ptr_phase_q;
      mack_d      = mack_q;
      sda_oe_d    = sda_oe_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      busy_d      = busy_q;

      // Read data returns one cycle after the request; it becomes the next byte out.
      if (rd_pend_q) begin
         shift_d  = bus.I_RDATA;
         sda_oe_d = ~bus.I_RDATA[7];
         ptr_d    = ptr_q + 8'd1;
      end

      case (state_q)
         ST_IDLE, ST_WAIT_STOP: ;

         ST_ADDR: begin
            if (scl_rise) begin
               shift_d = rx_byte;
               cnt_d   = cnt_q + 4'd1;
            end
            if (rx_done) begin
               if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = rx_byte[RW_BIT];
                  busy_d  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end
         end

         ST_PTR, ST_WR_DATA: begin
            if (scl_rise) begin
               shift_d = rx_byte;
               cnt_d   = cnt_q + 4'd1;
            end
            if (rx_done) begin
               state_d     = ST_WR_ACK;
               ptr_phase_d = (state_q == ST_PTR);
               if (state_q == ST_PTR) begin
                  ptr_d = rx_byte;
               end else begin
                  wr_en_d = 1'b1;
                  wdata_d = rx_byte;
               end
            end
         end

         // cnt 8: between 8th rise and the ACK clock; cnt 9: ACK clock seen high.
         ST_ADDR_ACK, ST_WR_ACK: begin
            if (scl_fall && cnt_q == 4'd8) sda_oe_d = ~ACK_LVL;
            if (scl_rise && cnt_q == 4'd8) cnt_d = 4'd9;
            if (scl_fall && cnt_q == 4'd9) begin
               sda_oe_d = 1'b0;
               cnt_d    = 4'd0;
               if (state_q == ST_WR_ACK) begin
                  state_d = ST_WR_DATA;
                  if (!ptr_phase_q) ptr_d = ptr_q + 8'd1;
               end else if (rw_q) begin
                  state_d = ST_RD_DATA;
                  rd_en_d = 1'b1;
               end else begin
                  state_d = ST_PTR;
               end
            end
         end

         ST_RD_DATA: begin
            if (scl_rise && cnt_q < 4'd8) cnt_d = cnt_q + 4'd1;
            if (scl_fall) begin
               if (cnt_q == 4'd8) begin
                  sda_oe_d = 1'b0;
                  state_d  = ST_RD_ACK;
               end else if (cnt_q != 4'd0) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end
            end
         end

         ST_RD_ACK: begin
            if (scl_rise && cnt_q == 4'd8) begin
               mack_d = (sda_lvl != NACK_LVL);
               cnt_d  = 4'd9;
            end
            if (scl_fall && cnt_q == 4'd9) begin
               cnt_d = 4'd0;
               if (mack_q) begin
                  state_d = ST_RD_DATA;
                  rd_en_d = 1'b1;
               end else begin
                  state_d = ST_WAIT_STOP;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Bus conditions override whatever the byte engine decided this cycle.
      if (start_det) begin
         state_d  = ST_ADDR;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
         wr_en_d  = 1'b0;
         rd_en_d  = 1'b0;
      end
      if (stop_det) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         wr_en_d  = 1'b0;
         rd_en_d  = 1'b0;
      end
   end

   // NOTE: clocked state uses non-blocking assignments only.
   always_ff @(posedge I_CLK or negedge I_RESETN) begin
      if (!I_RESETN) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         shift_q     <= 8'h00;
         ptr_q       <= 8'h00;
         wdata_q     <= 8'h00;
         rw_q        <= 1'b0;
         ptr_phase_q <= 1'b0;
         mack_q      <= 1'b0;
         sda_oe_q    <= 1'b0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_pend_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         wdata_q     <= wdata_d;
         rw_q        <= rw_d;
         ptr_phase_q <= ptr_phase_d;
         mack_q      <= mack_d;
         sda_oe_q    <= sda_oe_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         rd_pend_q   <= rd_en_q;
         busy_q      <= busy_d;
      end
   end

   assign bus.O_SDA_OE = sda_oe_q;
   assign bus.O_WR_EN  = wr_en_q;
   assign bus.O_RD_EN  = rd_en_q;
   assign bus.O_ADDR   = ptr_q;
   assign bus.O_WDATA  = wdata_q;
   assign bus.O_BUSY   = busy_q;

endmodule
